// File: rtl/pipe_stage_skid_reg.sv
// Pipeline register with a valid/ready handshake, a 2-entry skid buffer, and hold/flush bubble PC tracking.
// Optional perf counters (stall_cnt, flush_cnt) are built in when PIPE_STAGE_PERF_CNT_EN is defined.
module pipe_stage_skid_reg #(
  parameter int              DATA_W   = 128,
  parameter int              PC_W     = 32,
  parameter int              EXC_W    = 4,
  parameter logic [PC_W-1:0] RESET_PC = 32'h00003004,
  parameter logic [PC_W-1:0] EXC_PC   = 32'h00004184
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              hold,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              in_bd,
  input  logic [EXC_W-1:0]  in_exc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_bd,
`ifdef PIPE_STAGE_PERF_CNT_EN
  output logic [EXC_W-1:0]  out_exc,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`else
  output logic [EXC_W-1:0]  out_exc
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [PC_W-1:0]     main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic                main_bd_q, main_bd_d, skid_bd_q, skid_bd_d;
  logic [EXC_W-1:0]    main_exc_q, main_exc_d, skid_exc_q, skid_exc_d;
  logic [PC_W-1:0]     bubble_pc_q, bubble_pc_d;
  logic                bubble_bd_q, bubble_bd_d;
  logic                in_fire, out_fire;

  assign in_ready  = (state_q != TWO) & ~hold & ~flush;
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  assign out_data = out_valid ? main_data_q : '0;
  assign out_exc  = out_valid ? main_exc_q  : '0;
  assign out_pc   = out_valid ? main_pc_q   : bubble_pc_q;
  assign out_bd   = out_valid ? main_bd_q   : bubble_bd_q;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_pc_d   = main_pc_q;
    main_bd_d   = main_bd_q;
    main_exc_d  = main_exc_q;
    skid_data_d = skid_data_q;
    skid_pc_d   = skid_pc_q;
    skid_bd_d   = skid_bd_q;
    skid_exc_d  = skid_exc_q;
    bubble_pc_d = bubble_pc_q;
    bubble_bd_d = bubble_bd_q;
    if (flush) begin
      state_d     = EMPTY;
      main_data_d = '0;
      main_pc_d   = '0;
      main_bd_d   = 1'b0;
      main_exc_d  = '0;
      skid_data_d = '0;
      skid_pc_d   = '0;
      skid_bd_d   = 1'b0;
      skid_exc_d  = '0;
      bubble_pc_d = EXC_PC;
      bubble_bd_d = 1'b0;
    end else begin
      // A stalled instruction's PC/BD must survive into the bubble for EPC.
      if (hold) begin
        bubble_pc_d = in_pc;
        bubble_bd_d = in_bd;
      end
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_data_d = in_data;
            main_pc_d   = in_pc;
            main_bd_d   = in_bd;
            main_exc_d  = in_exc;
            state_d     = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_data_d = in_data;
            main_pc_d   = in_pc;
            main_bd_d   = in_bd;
            main_exc_d  = in_exc;
          end else if (in_fire) begin
            skid_data_d = in_data;
            skid_pc_d   = in_pc;
            skid_bd_d   = in_bd;
            skid_exc_d  = in_exc;
            state_d     = TWO;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            main_data_d = skid_data_q;
            main_pc_d   = skid_pc_q;
            main_bd_d   = skid_bd_q;
            main_exc_d  = skid_exc_q;
            skid_data_d = '0;
            skid_pc_d   = '0;
            skid_bd_d   = 1'b0;
            skid_exc_d  = '0;
            state_d     = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_pc_q   <= '0;
      main_bd_q   <= 1'b0;
      main_exc_q  <= '0;
      skid_data_q <= '0;
      skid_pc_q   <= '0;
      skid_bd_q   <= 1'b0;
      skid_exc_q  <= '0;
      bubble_pc_q <= RESET_PC;
      bubble_bd_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_pc_q   <= main_pc_d;
      main_bd_q   <= main_bd_d;
      main_exc_q  <= main_exc_d;
      skid_data_q <= skid_data_d;
      skid_pc_q   <= skid_pc_d;
      skid_bd_q   <= skid_bd_d;
      skid_exc_q  <= skid_exc_d;
      bubble_pc_q <= bubble_pc_d;
      bubble_bd_q <= bubble_bd_d;
    end
  end

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  // Saturating counters; a flush on an already empty stage kills nothing and is not counted.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hold && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush && (state_q != EMPTY) && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
